cnc_stepgen_bank: RTL and testbench
===================================

# cnc_stepgen_bank

Parametrised N-channel step/direction generator bank with an Avalon-MM slave register interface and a read-stroked watchdog. It is the next generation of the CNC stepgen front end and sits between the Nios/HPS Avalon fabric and the stepper-driver conduit. Over the fixed 5-axis stepgen, it adds:
- configurable step pulse width and direction setup time;
- missed-step detection;
- writable position counters;
- a watchdog that forces all channels off.

## Interface
- N_CH, 5: channel count, 1..8.
- STEP_HI, 100: step pulse high time in clk cycles, ≥1.
- DIR_SETUP, 50: cycles between a dir change and the next step rising edge, ≥1.
- WD_TIMEOUT, 50000000: idle cycles before the watchdog bites.
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk.
- chipselect, read, write  in  1 each  Avalon-MM controls.
- address  in  6  word address.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- osteps  out  N_CH  step outputs, active high.
- odirs  out  N_CH  direction outputs.
- wd_bite  out  1  sticky watchdog-expired flag.

## Operation
Register map:
- 0x00+i (i<N_CH): PERIOD[i], 32 bit, R/W. A value of 0 stops the channel.
- 0x10: CTRL, R/W.
  - [7:0] DIR_REQ; bit 1 = count up.
  - [15:8] EN.
  - Bits at or above N_CH write-ignored and read 0.
- 0x11: STATUS.
  - [0] wd_bite; W1C.
  - [15:8] missed-step sticky per channel; W1C.
  - [23:16] busy (channel not IDLE); RO.
- 0x20+i: POS[i], 32-bit signed. Read returns the position. Write loads it.
- Unmapped reads return 0. Unmapped writes are ignored.

Per-channel rate counter `cnt` (32 bit):
- While EN=1 and PERIOD≠0, `cnt` increments every cycle in every FSM state.
- When cnt ≥ PERIOD−1: cnt←0 and a fire event occurs. Using ≥ means shrinking PERIOD below cnt fires on the next cycle.
- If EN=0 or PERIOD=0: cnt←0, pending←0.

Per-channel FSM, states IDLE, SETUP, HIGH:
- IDLE, with fire or pending:
  - If DIR_REQ[i]≠odirs[i]: odirs[i]←DIR_REQ[i], go to SETUP.
  - Otherwise go to HIGH.
  - pending←0.
- SETUP: hold DIR_SETUP cycles, then go to HIGH.
- HIGH:
  - osteps[i]=1 for exactly STEP_HI cycles, then return to IDLE.
  - POS[i] updates by ±1 (per odirs[i]) on the cycle HIGH is entered.
- Fire while not IDLE:
  - If pending=0: pending←1.
  - If pending=1: set missed[i] and drop the event.
- odirs[i] changes only on the IDLE→SETUP transition; it is never changed while in SETUP or HIGH.
- EN cleared mid-step: the current SETUP/HIGH completes in full (no runt pulse), then the channel stays in IDLE.

Simultaneous events:
- POS write coincident with a step update: the write wins; that step's ±1 is lost.
- W1C coincident with a new set: the set wins.
- 32-bit POS wraps modulo 2^32.

## Timing
- Read latency 1: readdata is valid the cycle after chipselect&read is sampled, and holds until the next read.
- Writes take effect the cycle after sampling. A new EN or DIR_REQ is seen by the FSM on that cycle.
- Minimum step period is STEP_HI+1 cycles, or STEP_HI+DIR_SETUP+1 cycles across a direction change.
- Reset values:
  - osteps, odirs, readdata, wd_bite: 0.
  - All PERIOD, CTRL, POS, missed, cnt, pending: 0.
  - FSMs: IDLE.
- Reset asserted mid-pulse: osteps drops immediately (asynchronous).

## Configuration
CNC_STEPGEN_WDOG_EN defined:
- A 32-bit watchdog counter increments every cycle without chipselect&read, and clears on any read.
- When it reaches WD_TIMEOUT: wd_bite←1, and every channel behaves as EN=0 (effective enables masked; CTRL retains its value) until wd_bite is cleared.
- Clearing wd_bite also zeros the counter.

CNC_STEPGEN_WDOG_EN undefined: no counter; wd_bite and STATUS[0] are constant 0.

## Test plan
- Reset, then read every register → all 0; osteps=odirs=0 throughout.
- PERIOD[0]=1000, CTRL=0x0101 → odirs[0]=1 after DIR_SETUP. Steps rise every 1000 cycles, high 100 cycles each. POS[0]=10 after the 10th rising edge.
- Running channel 0, write DIR_REQ=0 → the current pulse completes. odirs[0] falls in IDLE; the next rise comes ≥50 cycles later. POS decrements from then on.
- PERIOD[1]=20 with STEP_HI=100 → STATUS[9] sets. Writing 0x200 to STATUS clears it, and it sets again while stepping continues.
- Write POS[2]=0xFFFFFFFF, then up-step once → POS[2]=0. A write coincident with a step edge reads back the written value exactly.
- With CNC_STEPGEN_WDOG_EN and WD_TIMEOUT=1000, no reads → wd_bite=1 at cycle 1000; all osteps quiet after the current pulse ends. Writing 1 to STATUS[0] resumes stepping.

Source files
------------

// File: rtl/cnc_stepgen_bank.sv
// N-channel step/direction generator bank with an Avalon-MM register slave.
// Optional read-stroked watchdog: define CNC_STEPGEN_WDOG_EN to build it in.
module cnc_stepgen_bank #(
  parameter int N_CH       = 5,
  parameter int STEP_HI    = 100,
  parameter int DIR_SETUP  = 50,
  parameter int WD_TIMEOUT = 50000000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            chipselect,
  input  logic            read,
  input  logic            write,
  input  logic [5:0]      address,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [N_CH-1:0] osteps,
  output logic [N_CH-1:0] odirs,
  output logic            wd_bite
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2
  } state_e;

  localparam logic [31:0] HI_LOAD    = 32'(STEP_HI - 1);
  localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);

  // Avalon-MM slave: a transfer is chipselect plus read or write in one cycle,
  // no wait states; readdata is registered and valid one cycle after the read.
  logic wr, rd, wr_ctrl, wr_status;
  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign wr_ctrl   = wr && (address == 6'h10);
  assign wr_status = wr && (address == 6'h11);

  logic [N_CH-1:0] dir_req_q, en_q, missed_q, miss_set, busy;
  logic [31:0]     period_w [N_CH];
  logic [31:0]     pos_w    [N_CH];
  state_e          ch_state [N_CH];
  logic [31:0]     readdata_q, rd_data;
  logic            wd_mask, wd_bite_w;

`ifdef CNC_STEPGEN_WDOG_EN
  localparam logic [31:0] WD_LIM  = 32'(WD_TIMEOUT);
  localparam logic [31:0] WD_LAST = 32'(WD_TIMEOUT - 1);

  logic [31:0] wd_cnt_q;
  logic        wd_bite_q, wd_clr, wd_hit;

  assign wd_clr = wr_status & writedata[0];
  assign wd_hit = !rd && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q  <= 32'd0;
      wd_bite_q <= 1'b0;
    end else begin
      // Counter saturates at the limit so an expired dog cannot re-arm by wrapping.
      if (wd_clr || rd)          wd_cnt_q <= 32'd0;
      else if (wd_cnt_q != WD_LIM) wd_cnt_q <= wd_cnt_q + 32'd1;
      if (wd_hit)      wd_bite_q <= 1'b1;
      else if (wd_clr) wd_bite_q <= 1'b0;
    end
  end

  assign wd_mask   = wd_bite_q;
  assign wd_bite_w = wd_bite_q;
`else
  assign wd_mask   = 1'b0;
  assign wd_bite_w = 1'b0;
`endif

  assign wd_bite  = wd_bite_w;
  assign readdata = readdata_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [31:0] period_q, cnt_q, pos_q, timer_q;
    state_e      state_q;
    logic        pending_q, osteps_q, odirs_q;
    logic        run, fire, go, wr_period, wr_pos, enter_high;

    assign wr_period = wr && (address == 6'(i));
    assign wr_pos    = wr && (address == 6'(32 + i));
    assign run       = en_q[i] && !wd_mask && (period_q != 32'd0);
    // >= so that shrinking PERIOD below the running count fires promptly.
    assign fire      = run && (cnt_q >= period_q - 32'd1);
    assign go        = fire || (pending_q && run);
    assign enter_high = (state_q == ST_IDLE && go && dir_req_q[i] == odirs_q) ||
                        (state_q == ST_SETUP && timer_q == 32'd0);
    assign miss_set[i] = fire && (state_q != ST_IDLE) && pending_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period_q  <= 32'd0;
        cnt_q     <= 32'd0;
        pos_q     <= 32'd0;
        timer_q   <= 32'd0;
        state_q   <= ST_IDLE;
        pending_q <= 1'b0;
        osteps_q  <= 1'b0;
        odirs_q   <= 1'b0;
      end else begin
        if (wr_period) period_q <= writedata;
        cnt_q <= (!run || fire) ? 32'd0 : cnt_q + 32'd1;
        if (!run || state_q == ST_IDLE) pending_q <= 1'b0;
        else if (fire)                  pending_q <= 1'b1;
        // A bus write to POS takes priority over the step's +-1.
        if (wr_pos)          pos_q <= writedata;
        else if (enter_high) pos_q <= odirs_q ? pos_q + 32'd1 : pos_q - 32'd1;
        case (state_q)
          ST_IDLE: begin
            if (go) begin
              if (dir_req_q[i] != odirs_q) begin
                odirs_q <= dir_req_q[i];
                timer_q <= SETUP_LOAD;
                state_q <= ST_SETUP;
              end else begin
                timer_q  <= HI_LOAD;
                osteps_q <= 1'b1;
                state_q  <= ST_HIGH;
              end
            end
          end
          ST_SETUP: begin
            if (timer_q == 32'd0) begin
              timer_q  <= HI_LOAD;
              osteps_q <= 1'b1;
              state_q  <= ST_HIGH;
            end else begin
              timer_q <= timer_q - 32'd1;
            end
          end
          ST_HIGH: begin
            if (timer_q == 32'd0) begin
              osteps_q <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              timer_q <= timer_q - 32'd1;
            end
          end
          default: begin
            osteps_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        endcase
      end
    end

    assign period_w[i] = period_q;
    assign pos_w[i]    = pos_q;
    assign ch_state[i] = state_q;
    assign busy[i]     = (state_q != ST_IDLE);
    assign osteps[i]   = osteps_q;
    assign odirs[i]    = odirs_q;
  end

  always_comb begin
    rd_data = 32'd0;
    for (int k = 0; k < N_CH; k++) begin
      if (address == 6'(k))      rd_data = period_w[k];
      if (address == 6'(32 + k)) rd_data = pos_w[k];
    end
    if (address == 6'h10) rd_data = {16'd0, 8'(en_q), 8'(dir_req_q)};
    if (address == 6'h11) rd_data = {8'd0, 8'(busy), 8'(missed_q), 7'd0, wd_bite_w};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_req_q  <= '0;
      en_q       <= '0;
      missed_q   <= '0;
      readdata_q <= 32'd0;
    end else begin
      if (wr_ctrl) begin
        dir_req_q <= writedata[N_CH-1:0];
        en_q      <= writedata[8 +: N_CH];
      end
      // New missed events win over a coincident write-1-to-clear.
      missed_q <= (missed_q & ~(wr_status ? writedata[8 +: N_CH] : '0)) | miss_set;
      if (rd) readdata_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_cnc_stepgen_bank.sv
// Directed bench for cnc_stepgen_bank: register map, step timing, direction
// changes, missed steps, POS wrap/write priority, watchdog, async reset.
module tb_cnc_stepgen_bank;
  localparam int N_CH = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            chipselect, read, write;
  logic [5:0]      address;
  logic [31:0]     writedata, readdata;
  logic [N_CH-1:0] osteps, odirs;
  logic            wd_bite;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  bit feed     = 1'b1;
  int e0       = 0;

  int   rise_q[$];
  int   fall_q[$];
  int   dir_rise_c = -1;
  int   dir_fall_c = -1;
  logic prev_step0 = 1'b0;
  logic prev_dir0  = 1'b0;

  cnc_stepgen_bank #(
    .N_CH(N_CH), .STEP_HI(100), .DIR_SETUP(50), .WD_TIMEOUT(1000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .writedata(writedata),
    .readdata(readdata), .osteps(osteps), .odirs(odirs), .wd_bite(wd_bite)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Edge recorder for channel 0, sampled on the falling edge.
  always @(negedge clk) begin
    if (osteps[0] && !prev_step0) rise_q.push_back(cyc_n);
    if (!osteps[0] && prev_step0) fall_q.push_back(cyc_n);
    if (odirs[0] && !prev_dir0)   dir_rise_c = cyc_n;
    if (!odirs[0] && prev_dir0)   dir_fall_c = cyc_n;
    prev_step0 <= osteps[0];
    prev_dir0  <= odirs[0];
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic set_idle();
    chipselect = feed;
    read       = feed;
    write      = 1'b0;
    address    = 6'h3F;
    writedata  = 32'd0;
  endtask

  task automatic idle_cycle();
    set_idle();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc_n < c) idle_cycle();
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(posedge clk); #1;
    d = readdata;
    set_idle();
  endtask

  task automatic test_reset();
    logic [5:0]  addr_list [15];
    logic [31:0] rdv;
    addr_list = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h10, 6'h11, 6'h20,
                  6'h21, 6'h22, 6'h23, 6'h24, 6'h05, 6'h12, 6'h3F};
    reset_n = 1'b0;
    set_idle();
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (osteps !== '0 || odirs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: osteps=%b odirs=%b expected 0", osteps, odirs);
      end
    end
    n_checks++;
    if (wd_bite !== 1'b0) begin
      n_fail++; $display("FAIL reset_wd_bite: got %b expected 0", wd_bite);
    end
    n_checks++;
    if (readdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_readdata: got %h expected 0", readdata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycle();
    foreach (addr_list[k]) begin
      bus_read(addr_list[k], rdv);
      n_checks++;
      if (rdv !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg[%h]: got %h expected 0", addr_list[k], rdv);
      end
    end
  endtask

  task automatic test_step_rate();
    logic [31:0] rdv;
    int exp_c;
    rise_q.delete(); fall_q.delete();
    bus_write(6'h00, 32'd1000);
    bus_write(6'h10, 32'h0101);
    e0 = cyc_n;
    while (rise_q.size() < 10 && cyc_n < e0 + 12000) idle_cycle();
    n_checks++;
    if (rise_q.size() != 10) begin
      n_fail++; $display("FAIL step_rise_count: got %0d expected 10", rise_q.size());
    end else begin
      n_checks++;
      if (dir_rise_c != e0 + 1000) begin
        n_fail++; $display("FAIL dir_setup_edge: got %0d expected %0d", dir_rise_c - e0, 1000);
      end
      for (int j = 0; j < 10; j++) begin
        exp_c = (j == 0) ? e0 + 1050 : e0 + 1000 * (j + 1);
        n_checks++;
        if (rise_q[j] != exp_c) begin
          n_fail++; $display("FAIL step_rise[%0d]: got %0d expected %0d", j, rise_q[j] - e0, exp_c - e0);
        end
      end
      for (int j = 0; j < 9; j++) begin
        n_checks++;
        if (j >= fall_q.size() || fall_q[j] - rise_q[j] != 100) begin
          n_fail++; $display("FAIL step_width[%0d]: got %0d expected 100", j,
                             (j < fall_q.size()) ? fall_q[j] - rise_q[j] : -1);
        end
      end
    end
    bus_read(6'h20, rdv);
    n_checks++;
    if (rdv !== 32'd10) begin
      n_fail++; $display("FAIL pos0_after_10: got %0d expected 10", rdv);
    end
    n_checks++;
    if (osteps[4:1] !== 4'b0) begin
      n_fail++; $display("FAIL idle_channels_quiet: got %b expected 0000", osteps[4:1]);
    end
  endtask

  task automatic test_dir_change();
    logic [31:0] rdv;
    bus_write(6'h10, 32'h0100);
    while (rise_q.size() < 12 && cyc_n < e0 + 12500) idle_cycle();
    n_checks++;
    if (rise_q.size() != 12 || fall_q.size() < 11) begin
      n_fail++; $display("FAIL dir_rise_count: got %0d expected 12", rise_q.size());
    end else begin
      n_checks++;
      if (fall_q[9] != e0 + 10100) begin
        n_fail++; $display("FAIL dir_pulse_completes: got %0d expected 10100", fall_q[9] - e0);
      end
      n_checks++;
      if (dir_fall_c != e0 + 11000) begin
        n_fail++; $display("FAIL dir_fall_edge: got %0d expected 11000", dir_fall_c - e0);
      end
      n_checks++;
      if (rise_q[10] != e0 + 11050) begin
        n_fail++; $display("FAIL dir_setup_gap: got %0d expected 11050", rise_q[10] - e0);
      end
      n_checks++;
      if (rise_q[11] != e0 + 12000) begin
        n_fail++; $display("FAIL dir_next_rise: got %0d expected 12000", rise_q[11] - e0);
      end
    end
    bus_read(6'h20, rdv);
    n_checks++;
    if (rdv !== 32'd8) begin
      n_fail++; $display("FAIL pos0_down: got %0d expected 8", rdv);
    end
    bus_write(6'h10, 32'h0000);
    wait_until(e0 + 13500);
    n_checks++;
    if (rise_q.size() != 12 || fall_q.size() != 12 || fall_q[11] != e0 + 12100) begin
      n_fail++; $display("FAIL en_clear_full_pulse: rises=%0d falls=%0d expected 12/12 last fall 12100",
                         rise_q.size(), fall_q.size());
    end
    bus_write(6'h00, 32'd0);
  endtask

  task automatic test_missed();
    logic [31:0] rdv;
    int e;
    bus_write(6'h01, 32'd20);
    bus_write(6'h10, 32'h0202);
    e = cyc_n;
    wait_until(e + 101);
    bus_read(6'h11, rdv);
    n_checks++;
    if (rdv !== 32'h0002_0200) begin
      n_fail++; $display("FAIL missed_set: got %h expected 00020200", rdv);
    end
    n_checks++;
    if (odirs !== 5'b00010) begin
      n_fail++; $display("FAIL missed_odirs: got %b expected 00010", odirs);
    end
    bus_write(6'h11, 32'h0000_0200);
    bus_read(6'h11, rdv);
    n_checks++;
    if (rdv !== 32'h0002_0000) begin
      n_fail++; $display("FAIL missed_w1c: got %h expected 00020000", rdv);
    end
    wait_until(e + 124);
    bus_read(6'h11, rdv);
    n_checks++;
    if (rdv !== 32'h0002_0200) begin
      n_fail++; $display("FAIL missed_reset: got %h expected 00020200", rdv);
    end
    bus_write(6'h10, 32'h0000);
    wait_until(e + 200);
    bus_write(6'h11, 32'h0000_0200);
    bus_read(6'h11, rdv);
    n_checks++;
    if (rdv !== 32'd0) begin
      n_fail++; $display("FAIL missed_idle_status: got %h expected 00000000", rdv);
    end
    bus_read(6'h21, rdv);
    n_checks++;
    if (rdv !== 32'd1) begin
      n_fail++; $display("FAIL pos1_single_step: got %0d expected 1", rdv);
    end
    bus_write(6'h01, 32'd0);
  endtask

  task automatic test_pos_wrap();
    logic [31:0] rdv;
    int e;
    bus_write(6'h22, 32'hFFFF_FFFF);
    bus_read(6'h22, rdv);
    n_checks++;
    if (rdv !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL pos2_load: got %h expected ffffffff", rdv);
    end
    bus_write(6'h02, 32'd200);
    bus_write(6'h10, 32'h0404);
    e = cyc_n;
    wait_until(e + 260);
    bus_write(6'h10, 32'h0000);
    wait_until(e + 400);
    bus_read(6'h22, rdv);
    n_checks++;
    if (rdv !== 32'd0) begin
      n_fail++; $display("FAIL pos2_wrap: got %h expected 00000000", rdv);
    end
    n_checks++;
    if (odirs[2] !== 1'b1) begin
      n_fail++; $display("FAIL pos2_dir: got %b expected 1", odirs[2]);
    end
    bus_write(6'h10, 32'h0404);
    e = cyc_n;
    wait_until(e + 199);
    bus_write(6'h22, 32'h1234_5678);
    n_checks++;
    if (osteps[2] !== 1'b1) begin
      n_fail++; $display("FAIL pos2_coincident_step: got %b expected 1", osteps[2]);
    end
    bus_write(6'h10, 32'h0000);
    bus_read(6'h22, rdv);
    n_checks++;
    if (rdv !== 32'h1234_5678) begin
      n_fail++; $display("FAIL pos2_write_wins: got %h expected 12345678", rdv);
    end
    bus_write(6'h02, 32'd0);
    wait_until(e + 400);
  endtask

  task automatic test_wdog();
    logic [31:0] rdv;
`ifdef CNC_STEPGEN_WDOG_EN
    int r;
    int w;
    int noisy;
    bus_write(6'h03, 32'd300);
    bus_write(6'h10, 32'h0808);
    feed = 1'b0;
    bus_read(6'h3F, rdv);
    r = cyc_n;
    wait_until(r + 999);
    n_checks++;
    if (wd_bite !== 1'b0) begin
      n_fail++; $display("FAIL wd_early: got %b expected 0", wd_bite);
    end
    idle_cycle();
    n_checks++;
    if (wd_bite !== 1'b1) begin
      n_fail++; $display("FAIL wd_bite_at_timeout: got %b expected 1", wd_bite);
    end
    noisy = 0;
    while (cyc_n < r + 1500) begin
      idle_cycle();
      if (osteps !== '0) noisy++;
    end
    n_checks++;
    if (noisy != 0) begin
      n_fail++; $display("FAIL wd_quiet: got %0d active cycles expected 0", noisy);
    end
    feed = 1'b1;
    bus_read(6'h10, rdv);
    n_checks++;
    if (rdv !== 32'h0000_0808) begin
      n_fail++; $display("FAIL wd_ctrl_kept: got %h expected 00000808", rdv);
    end
    bus_read(6'h11, rdv);
    n_checks++;
    if (rdv !== 32'h0000_0001) begin
      n_fail++; $display("FAIL wd_status: got %h expected 00000001", rdv);
    end
    bus_write(6'h11, 32'h0000_0001);
    w = cyc_n;
    n_checks++;
    if (wd_bite !== 1'b0) begin
      n_fail++; $display("FAIL wd_clear: got %b expected 0", wd_bite);
    end
    while (osteps[3] !== 1'b1 && cyc_n < w + 400) idle_cycle();
    n_checks++;
    if (cyc_n != w + 300) begin
      n_fail++; $display("FAIL wd_resume: got %0d expected 300", cyc_n - w);
    end
    bus_write(6'h10, 32'h0000);
    bus_write(6'h03, 32'd0);
    wait_until(w + 600);
`else
    feed = 1'b0;
    repeat (1200) idle_cycle();
    n_checks++;
    if (wd_bite !== 1'b0) begin
      n_fail++; $display("FAIL wd_absent_bite: got %b expected 0", wd_bite);
    end
    feed = 1'b1;
    bus_read(6'h11, rdv);
    n_checks++;
    if (rdv !== 32'd0) begin
      n_fail++; $display("FAIL wd_absent_status: got %h expected 00000000", rdv);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] rdv;
    int e;
    bus_write(6'h04, 32'd10);
    bus_write(6'h10, 32'h1010);
    e = cyc_n;
    while (osteps[4] !== 1'b1 && cyc_n < e + 200) idle_cycle();
    n_checks++;
    if (osteps[4] !== 1'b1) begin
      n_fail++; $display("FAIL async_pulse_start: got %b expected 1", osteps[4]);
    end else begin
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (osteps !== '0 || odirs !== '0) begin
        n_fail++; $display("FAIL async_reset_drop: osteps=%b odirs=%b expected 0", osteps, odirs);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycle();
    bus_read(6'h24, rdv);
    n_checks++;
    if (rdv !== 32'd0) begin
      n_fail++; $display("FAIL async_pos_cleared: got %h expected 00000000", rdv);
    end
    bus_read(6'h10, rdv);
    n_checks++;
    if (rdv !== 32'd0) begin
      n_fail++; $display("FAIL async_ctrl_cleared: got %h expected 00000000", rdv);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_step_rate();
    test_dir_change();
    test_missed();
    test_pos_wrap();
    test_wdog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
